// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit.
//   - RV32I major opcode constants
//   - FSM state enum (encoding is visible on state_o)
//   - Instruction class enum produced by rv_instr_decoder
//   - imm_sel / alu_op / pc_sel / wb_sel encodings
package rv_ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_ERR    = 3'd6,
    ST_TRAP   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    CLS_OP,
    CLS_OPIMM,
    CLS_LUI,
    CLS_AUIPC,
    CLS_JAL,
    CLS_JALR,
    CLS_BRANCH,
    CLS_LOAD,
    CLS_STORE,
    CLS_FENCE,
    CLS_SYSTEM,
    CLS_ILLEGAL
  } instr_cls_t;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  // alu_op = {sub/sra modifier, funct3}; all-ones selects operand B unchanged
  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b1000;
  localparam logic [3:0] ALU_PASS_B = 4'b1111;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_BR    = 2'b01;
  localparam logic [1:0] PC_JALR  = 2'b10;
  localparam logic [1:0] PC_TRAP  = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // Classes whose result is written back straight after EXEC
  function automatic logic is_alu_class(input instr_cls_t cls);
    return (cls == CLS_OP) || (cls == CLS_OPIMM) || (cls == CLS_LUI) ||
           (cls == CLS_AUIPC) || (cls == CLS_JAL) || (cls == CLS_JALR);
  endfunction

endpackage

// File: rtl/rv_instr_decoder.sv
// Combinational instruction decoder for the multi-cycle control unit.
// Maps opcode/funct3/instr[30] to an instruction class, immediate format
// and ALU controls. Carries no state.
// Ports:
//   opcode    in  7  instr[6:0]
//   funct3    in  3  instr[14:12]
//   bit30     in  1  instr[30] (sub/sra modifier)
//   cls       out    instruction class (CLS_ILLEGAL for unknown opcodes)
//   imm_sel   out 3  immediate format (I,S,B,U,J)
//   alu_op    out 4  {modifier, funct3}, or pass-B
//   alu_src_a out 1  0 rs1, 1 pc
//   alu_src_b out 1  0 rs2, 1 imm
module rv_instr_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       bit30,
  output instr_cls_t cls,
  output logic [2:0] imm_sel,
  output logic [3:0] alu_op,
  output logic       alu_src_a,
  output logic       alu_src_b
);

  always_comb begin
    cls       = CLS_ILLEGAL;
    imm_sel   = IMM_I;
    alu_op    = ALU_ADD;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        cls    = CLS_OP;
        alu_op = {bit30, funct3};
      end
      OPC_OPIMM: begin
        cls       = CLS_OPIMM;
        // instr[30] is immediate data except for the shift-right encodings
        alu_op    = {(funct3 == 3'b101) ? bit30 : 1'b0, funct3};
        alu_src_b = 1'b1;
      end
      OPC_LUI: begin
        cls       = CLS_LUI;
        imm_sel   = IMM_U;
        alu_op    = ALU_PASS_B;
        alu_src_b = 1'b1;
      end
      OPC_AUIPC: begin
        cls       = CLS_AUIPC;
        imm_sel   = IMM_U;
        alu_src_a = 1'b1;
        alu_src_b = 1'b1;
      end
      OPC_JAL: begin
        cls       = CLS_JAL;
        imm_sel   = IMM_J;
        alu_src_a = 1'b1;
        alu_src_b = 1'b1;
      end
      OPC_JALR: begin
        cls       = CLS_JALR;
        alu_src_b = 1'b1;
      end
      OPC_BRANCH: begin
        cls     = CLS_BRANCH;
        imm_sel = IMM_B;
        alu_op  = ALU_SUB;
      end
      OPC_LOAD: begin
        cls       = CLS_LOAD;
        alu_src_b = 1'b1;
      end
      OPC_STORE: begin
        cls       = CLS_STORE;
        imm_sel   = IMM_S;
        alu_src_b = 1'b1;
      end
      OPC_FENCE:  cls = CLS_FENCE;
      OPC_SYSTEM: cls = CLS_SYSTEM;
      default:    cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Sequencing control unit for the multi-cycle RV32I core.
// Walks IDLE/FETCH/DECODE/EXEC/MEM/WB and drives register-file, ALU,
// immediate, PC, memory and writeback controls. Memory accesses use a
// req/ack handshake with a bounded wait; a timeout parks the FSM in ERR
// with a sticky mem_err until reset.
// Optional feature: define ILLEGAL_TRAP_EN to route unknown opcodes through
// a one-cycle TRAP state (trap=1, PC <- trap vector). Without it unknown
// opcodes retire as NOPs and trap is tied low.
// Parameters: XLEN (kept for consistency), WAIT_W, MAX_WAIT (< 2**WAIT_W).
// Ports:
//   clk, rst_n (async, active-low)
//   instr[31:0]     IR contents, valid from DECODE onward
//   mem_ack         memory completes the current request
//   branch_taken    branch comparator result, used in EXEC
//   mem_req, mem_we, mem_size[1:0]   memory port controls
//   ir_load         IR load strobe
//   imm_sel[2:0], alu_src_a, alu_src_b, alu_op[3:0]   datapath controls
//   pc_we, pc_sel[1:0]   PC update
//   rf_we, wb_sel[1:0]   register writeback
//   mem_err         sticky memory-timeout flag
//   trap            one-cycle illegal-instruction pulse
//   state_o[2:0]    current state (debug)
module multicycle_ctrl_fsm
  import rv_ctrl_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ack,
  input  logic        branch_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic        ir_load,
  output logic [2:0]  imm_sel,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [3:0]  alu_op,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        mem_err,
  output logic        trap,
  output logic [2:0]  state_o
);

  if ((MAX_WAIT >= (1 << WAIT_W)) || (XLEN < 32)) begin : g_bad_params
    $error("multicycle_ctrl_fsm: MAX_WAIT must fit in WAIT_W bits and XLEN >= 32");
  end

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q;
  logic              timeout;

  instr_cls_t cls;
  logic [2:0] dec_imm_sel;
  logic [3:0] dec_alu_op;
  logic       dec_src_a;
  logic       dec_src_b;

  // Only opcode, funct3 and instr[30] steer control; the rest is datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  rv_instr_decoder u_dec (
    .opcode   (instr[6:0]),
    .funct3   (instr[14:12]),
    .bit30    (instr[30]),
    .cls      (cls),
    .imm_sel  (dec_imm_sel),
    .alu_op   (dec_alu_op),
    .alu_src_a(dec_src_a),
    .alu_src_b(dec_src_b)
  );

  assign timeout = (wait_cnt_q == WAIT_W'(MAX_WAIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (state_d == ST_ERR) mem_err_q <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_size   = 2'b00;
    ir_load    = 1'b0;
    imm_sel    = IMM_I;
    alu_src_a  = 1'b0;
    alu_src_b  = 1'b0;
    alu_op     = ALU_ADD;
    pc_we      = 1'b0;
    pc_sel     = PC_PLUS4;
    rf_we      = 1'b0;
    wb_sel     = WB_ALU;
    trap       = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;

      ST_FETCH: begin
        mem_req = 1'b1;
        // An ack in the final allowed cycle still completes the fetch
        if (mem_ack) begin
          ir_load = 1'b1;
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d = ST_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      ST_DECODE: begin
        imm_sel = dec_imm_sel;
        state_d = ST_EXEC;
      end

      ST_EXEC: begin
        imm_sel   = dec_imm_sel;
        alu_op    = dec_alu_op;
        alu_src_a = dec_src_a;
        alu_src_b = dec_src_b;
        if (is_alu_class(cls)) begin
          state_d = ST_WB;
        end else begin
          case (cls)
            CLS_BRANCH: begin
              pc_we   = 1'b1;
              pc_sel  = branch_taken ? PC_BR : PC_PLUS4;
              state_d = ST_FETCH;
            end
            CLS_LOAD, CLS_STORE: state_d = ST_MEM;
            CLS_FENCE, CLS_SYSTEM: begin
              pc_we   = 1'b1;
              state_d = ST_FETCH;
            end
            default: begin
`ifdef ILLEGAL_TRAP_EN
              state_d = ST_TRAP;
`else
              pc_we   = 1'b1;
              state_d = ST_FETCH;
`endif
            end
          endcase
        end
      end

      ST_MEM: begin
        mem_req  = 1'b1;
        mem_we   = (cls == CLS_STORE);
        mem_size = instr[13:12];
        if (mem_ack) begin
          if (cls == CLS_STORE) begin
            pc_we   = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (timeout) begin
          state_d = ST_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      ST_WB: begin
        // rd=x0 is still strobed; the register file discards it
        rf_we = 1'b1;
        pc_we = 1'b1;
        case (cls)
          CLS_LOAD: wb_sel = WB_MEM;
          CLS_JAL: begin
            wb_sel = WB_PC4;
            pc_sel = PC_BR;
          end
          CLS_JALR: begin
            wb_sel = WB_PC4;
            pc_sel = PC_JALR;
          end
          default: wb_sel = WB_ALU;
        endcase
        state_d = ST_FETCH;
      end

      ST_ERR: state_d = ST_ERR;

`ifdef ILLEGAL_TRAP_EN
      ST_TRAP: begin
        trap    = 1'b1;
        pc_we   = 1'b1;
        pc_sel  = PC_TRAP;
        state_d = ST_FETCH;
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_err = mem_err_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
`timescale 1ns/1ps
module tb_multicycle_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        mem_ack;
  logic        branch_taken;
  logic        mem_req, mem_we, ir_load, alu_src_a, alu_src_b;
  logic        pc_we, rf_we, mem_err, trap;
  logic [1:0]  mem_size, pc_sel, wb_sel;
  logic [2:0]  imm_sel, state_o;
  logic [3:0]  alu_op;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC = 3;
  localparam int S_MEM = 4, S_WB = 5, S_ERR = 6, S_TRAP = 7;

  multicycle_ctrl_fsm dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .mem_ack     (mem_ack),
    .branch_taken(branch_taken),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_size    (mem_size),
    .ir_load     (ir_load),
    .imm_sel     (imm_sel),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .pc_we       (pc_we),
    .pc_sel      (pc_sel),
    .rf_we       (rf_we),
    .wb_sel      (wb_sel),
    .mem_err     (mem_err),
    .trap        (trap),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called in a FETCH cycle; walks one ALU-class instruction to the next FETCH
  task automatic run_alu(input string nm, input logic [31:0] ins, input int e_imm,
                         input int e_alu, input int e_a, input int e_b,
                         input int e_wb, input int e_pc);
    instr   = ins;
    mem_ack = 1'b1;
    #1;
    chk({nm, ".ir_load"}, 32'(ir_load), 1);
    cyc();
    chk({nm, ".dec_state"}, 32'(state_o), S_DECODE);
    chk({nm, ".imm_sel"}, 32'(imm_sel), e_imm);
    cyc();
    chk({nm, ".exec_state"}, 32'(state_o), S_EXEC);
    chk({nm, ".alu_op"}, 32'(alu_op), e_alu);
    chk({nm, ".src_a"}, 32'(alu_src_a), e_a);
    chk({nm, ".src_b"}, 32'(alu_src_b), e_b);
    chk({nm, ".exec_pc_we"}, 32'(pc_we), 0);
    cyc();
    chk({nm, ".wb_state"}, 32'(state_o), S_WB);
    chk({nm, ".rf_we"}, 32'(rf_we), 1);
    chk({nm, ".wb_sel"}, 32'(wb_sel), e_wb);
    chk({nm, ".wb_pc_we"}, 32'(pc_we), 1);
    chk({nm, ".wb_pc_sel"}, 32'(pc_sel), e_pc);
    cyc();
    chk({nm, ".next_fetch"}, 32'(state_o), S_FETCH);
  endtask

  // Reset pulse ending in the first FETCH cycle
  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    instr        = 32'h0;
    mem_ack      = 1'b0;
    branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.state", 32'(state_o), S_IDLE);
    chk("rst.mem_req", 32'(mem_req), 0);
    chk("rst.mem_err", 32'(mem_err), 0);
    chk("rst.pc_we", 32'(pc_we), 0);
    chk("rst.rf_we", 32'(rf_we), 0);

    rst_n   = 1'b1;
    mem_ack = 1'b1;
    #1;
    chk("idle.mem_req", 32'(mem_req), 0);
    cyc();
    chk("fetch.state", 32'(state_o), S_FETCH);
    chk("fetch.mem_req", 32'(mem_req), 1);

    // ALU class: name, instr, imm_sel, alu_op, src_a, src_b, wb_sel, pc_sel
    run_alu("add",   32'h002081B3, 0, 'h0, 0, 0, 0, 0);
    run_alu("sub",   32'h402081B3, 0, 'h8, 0, 0, 0, 0);
    run_alu("srai",  32'h4010D193, 0, 'hD, 0, 1, 0, 0);
    run_alu("addi",  32'h40008193, 0, 'h0, 0, 1, 0, 0);
    run_alu("lui",   32'h123450B7, 3, 'hF, 0, 1, 0, 0);
    run_alu("auipc", 32'h00001097, 3, 'h0, 1, 1, 0, 0);
    run_alu("jal",   32'h000000EF, 4, 'h0, 1, 1, 2, 1);
    run_alu("jalr",  32'h000080E7, 0, 'h0, 0, 1, 2, 2);

    // Load with three wait cycles in MEM
    instr = 32'h0080A283;
    cyc();
    chk("lw.imm_sel", 32'(imm_sel), 0);
    mem_ack = 1'b0;
    cyc();
    chk("lw.src_b", 32'(alu_src_b), 1);
    chk("lw.alu_op", 32'(alu_op), 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("lw.mem_state", 32'(state_o), S_MEM);
      chk("lw.mem_req", 32'(mem_req), 1);
      chk("lw.mem_we", 32'(mem_we), 0);
      chk("lw.mem_size", 32'(mem_size), 2);
    end
    cyc();
    mem_ack = 1'b1;
    #1;
    chk("lw.ack_mem_req", 32'(mem_req), 1);
    chk("lw.ack_pc_we", 32'(pc_we), 0);
    cyc();
    chk("lw.wb_state", 32'(state_o), S_WB);
    chk("lw.rf_we", 32'(rf_we), 1);
    chk("lw.wb_sel", 32'(wb_sel), 1);
    chk("lw.pc_sel", 32'(pc_sel), 0);
    cyc();
    chk("lw.next_fetch", 32'(state_o), S_FETCH);

    // Store, zero-wait
    instr = 32'h0020A423;
    cyc();
    chk("sw.imm_sel", 32'(imm_sel), 1);
    cyc();
    chk("sw.src_b", 32'(alu_src_b), 1);
    cyc();
    chk("sw.mem_state", 32'(state_o), S_MEM);
    chk("sw.mem_we", 32'(mem_we), 1);
    chk("sw.mem_size", 32'(mem_size), 2);
    chk("sw.pc_we", 32'(pc_we), 1);
    chk("sw.pc_sel", 32'(pc_sel), 0);
    chk("sw.rf_we", 32'(rf_we), 0);
    cyc();
    chk("sw.next_fetch", 32'(state_o), S_FETCH);

    // Branch taken then not taken
    for (int t = 1; t >= 0; t--) begin
      instr = 32'h00208463;
      cyc();
      chk("beq.imm_sel", 32'(imm_sel), 2);
      cyc();
      branch_taken = t[0];
      #1;
      chk("beq.alu_op", 32'(alu_op), 'h8);
      chk("beq.pc_we", 32'(pc_we), 1);
      chk("beq.pc_sel", 32'(pc_sel), t);
      chk("beq.rf_we", 32'(rf_we), 0);
      cyc();
      chk("beq.next_fetch", 32'(state_o), S_FETCH);
    end
    branch_taken = 1'b0;

    // FENCE retires as NOP
    instr = 32'h0000000F;
    cyc();
    cyc();
    chk("fence.pc_we", 32'(pc_we), 1);
    chk("fence.pc_sel", 32'(pc_sel), 0);
    cyc();
    chk("fence.next_fetch", 32'(state_o), S_FETCH);

    // Unknown opcode
    instr = 32'h0000007F;
    cyc();
    cyc();
    chk("ill.exec_state", 32'(state_o), S_EXEC);
    chk("ill.exec_trap", 32'(trap), 0);
`ifdef ILLEGAL_TRAP_EN
    chk("ill.exec_pc_we", 32'(pc_we), 0);
    cyc();
    chk("ill.trap_state", 32'(state_o), S_TRAP);
    chk("ill.trap", 32'(trap), 1);
    chk("ill.pc_we", 32'(pc_we), 1);
    chk("ill.pc_sel", 32'(pc_sel), 3);
    cyc();
    chk("ill.trap_clear", 32'(trap), 0);
`else
    chk("ill.pc_we", 32'(pc_we), 1);
    chk("ill.pc_sel", 32'(pc_sel), 0);
    cyc();
    chk("ill.trap_low", 32'(trap), 0);
`endif
    chk("ill.next_fetch", 32'(state_o), S_FETCH);

    // Reset asserted mid-MEM wait
    instr = 32'h0080A283;
    cyc();
    cyc();
    mem_ack = 1'b0;
    cyc();
    chk("rstmem.mem_req", 32'(mem_req), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmem.req_drop", 32'(mem_req), 0);
    chk("rstmem.state", 32'(state_o), S_IDLE);
    chk("rstmem.rf_we", 32'(rf_we), 0);
    cyc();
    rst_n = 1'b1;
    chk("rstmem.still_idle", 32'(state_o), S_IDLE);
    cyc();
    chk("rstmem.fetch", 32'(state_o), S_FETCH);

    // Ack in the last allowed FETCH cycle beats the timeout
    for (int i = 0; i < 15; i++) cyc();
    chk("lastack.state", 32'(state_o), S_FETCH);
    mem_ack = 1'b1;
    #1;
    chk("lastack.ir_load", 32'(ir_load), 1);
    cyc();
    chk("lastack.decode", 32'(state_o), S_DECODE);
    chk("lastack.mem_err", 32'(mem_err), 0);

    // No ack ever: timeout into ERR
    mem_ack = 1'b0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      chk("tmo.fetch", 32'(state_o), S_FETCH);
      cyc();
    end
    chk("tmo.state", 32'(state_o), S_ERR);
    chk("tmo.mem_err", 32'(mem_err), 1);
    chk("tmo.mem_req", 32'(mem_req), 0);
    chk("tmo.pc_we", 32'(pc_we), 0);
    chk("tmo.rf_we", 32'(rf_we), 0);
    mem_ack = 1'b1;
    cyc();
    cyc();
    chk("tmo.stuck", 32'(state_o), S_ERR);
    chk("tmo.sticky", 32'(mem_err), 1);
    chk("tmo.ir_load", 32'(ir_load), 0);
    rst_n = 1'b0;
    #1;
    chk("tmo.clr_err", 32'(mem_err), 0);
    chk("tmo.clr_state", 32'(state_o), S_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
